instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming RV64 instruction encoder/loader: packs opcode, register, funct and 64-bit sign-extended immediate fields into 32-bit instruction words and writes them sequentially into instruction memory.
- Exact inverse of the core's immediate generator. For every accepted instruction, decoding the emitted word's immediate returns the input imm.
- Used by the bench and boot path to load programs without hand-assembled hex.

Parameters:
- BASE_ADDR, 64'h0, byte address of the first instruction written after start.
- DEPTH, 64, maximum instructions per load session. Power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle this cycle.
- in_last  input  1  final instruction of the session.
- opcode  input  7  instruction opcode.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field; R-type only.
- imm  input  64  sign-extended immediate. Branch imm is a halfword offset.
- mem_we  output  1  instruction-memory write strobe, one cycle per instruction.
- mem_addr  output  64  byte write address.
- mem_wdata  output  32  encoded instruction.
- busy  output  1  state is RUN.
- done  output  1  state is DONE.
- err  output  1  sticky: at least one bundle rejected this session.
- instr_count  output  $clog2(DEPTH)+1  instructions written this session.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; all outputs 0, including in_ready; internal write address = BASE_ADDR. Takes effect immediately, even mid-session or during a write cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE on acceptance of in_last, or when instr_count reaches DEPTH.
  - DONE -> RUN on start.
  - start in RUN is ignored.
- Entering RUN: address <= BASE_ADDR, instr_count <= 0, err <= 0.
- in_ready = 1 only when state is RUN and instr_count < DEPTH. An accept is in_valid & in_ready.
- Throughput and latency:
  - One accept per cycle sustained.
  - The registered write appears the cycle after the accept: mem_we=1, mem_addr = current address, mem_wdata = encoded word.
  - Address then increments by 4 and instr_count by 1.
  - mem_we is 0 in all other cycles.
- Encoding (funct3 -> [14:12], rs1 -> [19:15], rd -> [11:7], rs2 -> [24:20]):
  - 0000011 load, I-type: [31:20]=imm[11:0], plus rs1, funct3, rd.
  - 0010011 ALU-immediate, I-type: same packing as load.
  - 0100011 store, S-type: [31:25]=imm[11:5], [11:7]=imm[4:0], plus rs2, rs1, funct3.
  - 1100011 branch, SB-type: [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0], plus rs2, rs1, funct3.
  - 0110011 R-type: [31:25]=funct7, plus rs2, rs1, funct3, rd; imm ignored.
  - [6:0] = opcode in every case.
- Range rule for I/S/SB: imm[63:11] must be all-equal, i.e. a 12-bit signed value.
- Reject on illegal opcode or out-of-range imm:
  - Bundle is consumed; no write; address and count unchanged.
  - err <= 1 next cycle, sticky until the next start.
  - A rejected in_last still moves RUN -> DONE.
- Count limit: when the write makes instr_count == DEPTH, go to DONE and drop in_ready the same cycle the count updates.
- done is a level, held in DONE until start.

Test Plan:
- start; back-to-back accepts of addi x1,x0,5 then add x3,x1,x2 with in_last -> mem_wdata 0x00500093 at BASE_ADDR, then 0x002081B3 at BASE_ADDR+4 on consecutive cycles; done=1; instr_count=2.
- ld x2,-8(x1) (funct3=011, imm=-8) -> 0xFF80B103. sd x2,16(x1) (funct3=011, imm=16) -> 0x0020B823.
- beq x1,x2 with imm=-2 -> 0xFE208EE3. Feeding this word to the immediate generator returns 64'hFFFF_FFFF_FFFF_FFFE.
- addi with imm=2048, then opcode 0000000, then addi imm=-2048 -> two cycles with no mem_we, err=1; next write 0x80000013 at BASE_ADDR, instr_count=1.
- DEPTH=4, continuous in_valid, no in_last -> 4 writes, in_ready=0 after the 4th, done=1; further in_valid ignored; start re-enters RUN with err=0 and count=0.
- reset_n low for one cycle mid-RUN, coincident with a pending write -> mem_we stays 0, outputs clear immediately, IDLE; in_ready=0 until start.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming RV64 instruction encoder / program loader.
//
// Packs opcode, register, funct and a 64-bit sign-extended immediate into a
// 32-bit instruction word. Each encoded word is written into instruction memory
// at consecutive word addresses starting at BASE_ADDR. The immediate packing is
// the exact inverse of the core's immediate generator.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse that opens a load session (from IDLE or DONE)
//   in_valid / in_ready   field-bundle handshake; accept = in_valid & in_ready
//   in_last               marks the final bundle of the session
//   opcode, rd, rs1, rs2  instruction fields
//   funct3, funct7        function fields (funct7 used by R-type only)
//   imm                   64-bit sign-extended immediate (branch: halfword offset)
//   mem_we/addr/wdata     registered instruction-memory write port
//   busy, done            session is running / session has finished
//   err                   sticky: a bundle was rejected during this session
//   instr_count           instructions written during this session
module instr_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned DEPTH     = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [63:0]              imm,
  output logic                     mem_we,
  output logic [63:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   instr_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] CntOne   = CW'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [1:0]    state_q, state_d;
  logic [63:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          mem_we_q, mem_we_d;
  logic [63:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic        imm_ok;
  logic        legal;
  logic [31:0] word;
  logic        accept;

  // A 12-bit signed immediate has bits 63..11 all copies of the sign bit.
  always_comb begin
    imm_ok = (&imm[63:11]) | ~(|imm[63:11]);
    word   = '0;
    legal  = 1'b0;
    case (opcode)
      OpLoad, OpAluImm: begin
        word  = {imm[11:0], rs1, funct3, rd, opcode};
        legal = imm_ok;
      end
      OpStore: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = imm_ok;
      end
      OpBranch: begin
        // imm is already a halfword offset, so imm[0] lands in bit 8.
        word  = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
        legal = imm_ok;
      end
      OpReg: begin
        word  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready    = (state_q == StRun) && (count_q < DepthCnt);
    accept      = in_valid & in_ready;

    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          addr_d  = BASE_ADDR;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        if (accept) begin
          if (legal) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = word;
            addr_d      = addr_q + 64'd4;
            count_d     = count_q + CntOne;
          end else begin
            err_d = 1'b1;
          end
          // Rejected in_last still closes the session.
          if (in_last || (count_d == DepthCnt)) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= BASE_ADDR;
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    mem_we      = mem_we_q;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    busy        = (state_q == StRun);
    done        = (state_q == StDone);
    err         = err_q;
    instr_count = count_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios plus randomized sessions,
// compared every cycle against a behavioural model of the loader.
module tb_instr_encoder;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_1000;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic [6:0]    funct7 = '0;
  logic [63:0]   imm = '0;
  logic          mem_we;
  logic [63:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct3      (funct3),
    .funct7      (funct7),
    .imm         (imm),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [63:0] im, output bit ok);
    longint      sv       = longint'(im);
    bit          in_range = (sv >= -2048) && (sv <= 2047);
    logic [31:0] u12      = 32'(im[11:0]);
    logic [31:0] common   = (32'(f3) << 12) | (32'(s1) << 15) | 32'(op);
    case (op)
      7'h03, 7'h13: begin
        ok = in_range;
        return common | (u12 << 20) | (32'(d) << 7);
      end
      7'h23: begin
        ok = in_range;
        return common | (32'(s2) << 20) | ((u12 / 32) << 25) | ((u12 % 32) << 7);
      end
      7'h63: begin
        ok = in_range;
        return common | (32'(s2) << 20) | ((u12 / 2048) << 31) | (((u12 / 1024) % 2) << 7)
               | (((u12 / 16) % 64) << 25) | ((u12 % 16) << 8);
      end
      7'h33: begin
        ok = 1'b1;
        return common | (32'(s2) << 20) | (32'(f7) << 25) | (32'(d) << 7);
      end
      default: begin
        ok = 1'b0;
        return 32'h0;
      end
    endcase
  endfunction

  // Core immediate generator for the branch form (halfword offset).
  function automatic logic [63:0] branch_imm(input logic [31:0] w);
    longint v = (longint'(w[31]) * -2048) + longint'(w[7]) * 1024
                + longint'(w[30:25]) * 16 + longint'(w[11:8]);
    return 64'(v);
  endfunction

  // Behavioural model of the loader, updated at each active edge.
  bit          m_run = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  int          m_cnt = 0;
  logic [63:0] m_addr = BASE;
  bit          m_we = 0;
  logic [63:0] m_waddr = '0;
  logic [31:0] m_wdata = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_done = 0; m_err = 0; m_cnt = 0; m_addr = BASE;
      m_we = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      bit          acc;
      bit          ok;
      logic [31:0] enc;
      acc  = in_valid && m_run && (m_cnt < DEPTH);
      m_we = 0;
      if (acc) begin
        enc = ref_encode(opcode, rd, rs1, rs2, funct3, funct7, imm, ok);
        if (ok) begin
          m_we = 1; m_waddr = m_addr; m_wdata = enc;
          m_addr = m_addr + 4; m_cnt++;
        end else begin
          m_err = 1;
        end
        if (in_last || m_cnt == DEPTH) begin
          m_run = 0; m_done = 1;
        end
      end else if (start && !m_run) begin
        m_run = 1; m_done = 0; m_addr = BASE; m_cnt = 0; m_err = 0;
      end
    end
  end

  always @(negedge clk) begin
    check_eq("mem_we", 64'(mem_we), 64'(m_we));
    if (m_we) begin
      check_eq("mem_addr", mem_addr, m_waddr);
      check_eq("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    check_eq("busy", 64'(busy), 64'(m_run));
    check_eq("done", 64'(done), 64'(m_done));
    check_eq("err", 64'(err), 64'(m_err));
    check_eq("instr_count", 64'(instr_count), 64'(m_cnt));
    check_eq("in_ready", 64'(in_ready), 64'(m_run && (m_cnt < DEPTH)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [63:0] im, input logic last);
    in_valid = 1'b1; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; in_last = last;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [6] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h00};

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    tick();

    // addi x1,x0,5 ; add x3,x1,x2 back to back
    pulse_start();
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5, 1'b0);
    check_eq("addi_word", 64'(mem_wdata), 64'h0050_0093);
    check_eq("addi_addr", mem_addr, BASE);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0, 1'b1);
    idle();
    check_eq("add_we", 64'(mem_we), 64'd1);
    check_eq("add_word", 64'(mem_wdata), 64'h0020_81B3);
    check_eq("add_addr", mem_addr, BASE + 64'd4);
    check_eq("sess1_done", 64'(done), 64'd1);
    check_eq("sess1_count", 64'(instr_count), 64'd2);
    tick();

    // ld / sd / beq
    pulse_start();
    send(7'h03, 5'd2, 5'd1, 5'd0, 3'd3, 7'd0, -64'sd8, 1'b0);
    check_eq("ld_word", 64'(mem_wdata), 64'hFF80_B103);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd3, 7'd0, 64'd16, 1'b0);
    check_eq("sd_word", 64'(mem_wdata), 64'h0020_B823);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd2, 1'b1);
    idle();
    check_eq("beq_word", 64'(mem_wdata), 64'hFE20_8EE3);
    check_eq("beq_imm_roundtrip", branch_imm(mem_wdata), 64'hFFFF_FFFF_FFFF_FFFE);
    tick();

    // out-of-range imm, illegal opcode, then imm=-2048
    pulse_start();
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, 1'b0);
    check_eq("rej_range_we", 64'(mem_we), 64'd0);
    check_eq("rej_range_err", 64'(err), 64'd1);
    send(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);
    check_eq("rej_op_we", 64'(mem_we), 64'd0);
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd2048, 1'b1);
    idle();
    check_eq("min_imm_word", 64'(mem_wdata), 64'h8000_0013);
    check_eq("min_imm_addr", mem_addr, BASE);
    check_eq("min_imm_count", 64'(instr_count), 64'd1);
    tick();

    // depth limit: one reject, then continuous valid with no in_last
    pulse_start();
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 64'(i), 1'b0);
    end
    check_eq("limit_count", 64'(instr_count), 64'(DEPTH));
    check_eq("limit_ready", 64'(in_ready), 64'd0);
    check_eq("limit_done", 64'(done), 64'd1);
    check_eq("limit_we", 64'(mem_we), 64'd0);
    idle();
    pulse_start();
    check_eq("restart_err", 64'(err), 64'd0);
    check_eq("restart_count", 64'(instr_count), 64'd0);
    check_eq("restart_busy", 64'(busy), 64'd1);

    // asynchronous reset while a write is on the port and another is pending
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 1'b0);
    check_eq("pre_rst_we", 64'(mem_we), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_we", 64'(mem_we), 64'd0);
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    check_eq("async_rst_ready", 64'(in_ready), 64'd0);
    check_eq("async_rst_count", 64'(instr_count), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    idle();
    tick();
    check_eq("post_rst_ready", 64'(in_ready), 64'd0);

    // randomized sessions
    for (int c = 0; c < 600; c++) begin
      start    = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_last  = ($urandom_range(0, 5) == 0);
      opcode   = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 15) == 0) opcode = 7'($urandom);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = 64'(longint'($urandom_range(0, 4095)) - 2048);
        1:       imm = {$urandom, $urandom};
        2:       imm = ($urandom_range(0, 1) != 0) ? 64'd2047 : 64'd2048;
        default: imm = ($urandom_range(0, 1) != 0) ? -64'sd2048 : -64'sd2049;
      endcase
      tick();
    end
    start = 1'b0;
    idle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
